// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, store-buffer entry type and lane helpers
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // index is sized for the largest possible word address; the top only
   // ever fills the low clog2(DEPTH_WORDS) bits
   typedef struct packed {
      logic [29:0] index;
      logic [31:0] data;
      logic [3:0]  mask;
   } sbEntry_t;

   localparam int SB_ENTRY_W = $bits(sbEntry_t);

   function automatic logic isStoreOp(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
   endfunction

   // 4-bit shift drops lanes past byte 3, so unaligned halves lose their top byte
   function automatic logic [3:0] laneMask(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         F3_B:    return 4'b0001 << offset;
         F3_H:    return 4'b0011 << offset;
         F3_W:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] laneData(input logic [31:0] data, input logic [2:0] funct3,
                                            input logic [1:0] offset);
      if (funct3 == F3_W)
         return data;
      return data << {offset, 3'b000};
   endfunction

   // Bytes above the word end are zero; loads never reach into the next word
   function automatic logic [31:0] extractLoad(input logic [31:0] word, input logic [2:0] funct3,
                                               input logic [1:0] offset);
      logic [31:0] shifted;
      shifted = word >> {offset, 3'b000};
      case (funct3)
         F3_B:    return {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   return {24'd0, shifted[7:0]};
         F3_H:    return {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   return {16'd0, shifted[15:0]};
         F3_W:    return word;
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_store_buf.sv
// rtl/dmem_store_buf.sv - store FIFO with per-byte youngest-match load forwarding
module dmem_store_buf
   import dmem_pkg::*;
#(
   parameter int SB_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [SB_ENTRY_W-1:0]   pushEntry,
   input  logic                    pop,
   input  logic [29:0]             lookupIndex,
   input  logic [31:0]             baseWord,
   output logic [31:0]             mergedWord,
   output logic [SB_ENTRY_W-1:0]   headEntry,
   output logic [$clog2(SB_DEPTH):0] count
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   sbEntry_t           entries [SB_DEPTH];
   logic [PTR_W-1:0]   wrPtr;
   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   slot;

   // Entry storage needs no reset; only pointers decide what is valid
   always_ff @(posedge clk) begin
      if (push)
         entries[wrPtr] <= sbEntry_t'(pushEntry);
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push)
            wrPtr <= wrPtr + PTR_W'(1);
         if (pop)
            rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign headEntry = entries[rdPtr];

   // Walk oldest to youngest so later matches overwrite earlier bytes
   always_comb begin
      mergedWord = baseWord;
      slot       = rdPtr;
      for (int i = 0; i < SB_DEPTH; i++) begin
         slot = rdPtr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (entries[slot].index == lookupIndex)) begin
            for (int b = 0; b < 4; b++) begin
               if (entries[slot].mask[b])
                  mergedWord[8*b +: 8] = entries[slot].data[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data memory with store buffer; DMEM_MISALIGN_TRAP_EN enables misalign trap
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int SB_DEPTH    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      MemWrite,
   input  logic                      MemRead,
   input  logic [31:0]               Mem_WrAddr,
   input  logic [31:0]               Mem_WrData,
   input  logic [2:0]                funct3,
   output logic [31:0]               ReadData,
   output logic [$clog2(SB_DEPTH):0] SBCount,
   output logic                      SBEmpty,
   output logic                      MisalignErr
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]            mem [DEPTH_WORDS];
   logic [AW-1:0]          wordIdx;
   logic [1:0]             offset;
   logic                   misaligned;
   logic                   push;
   logic                   drain;
   sbEntry_t               pushEntry;
   sbEntry_t               head;
   logic [SB_ENTRY_W-1:0]  headVec;
   logic [31:0]            mergedWord;

   assign wordIdx = Mem_WrAddr[AW+1:2];
   assign offset  = Mem_WrAddr[1:0];

`ifdef DMEM_MISALIGN_TRAP_EN
   logic errFlag;

   assign misaligned = (MemRead || MemWrite) &&
                       ((((funct3 == F3_H) || (funct3 == F3_HU)) && offset[0]) ||
                        ((funct3 == F3_W) && (offset != 2'b00)));

   // Sticky trap flag, cleared only by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         errFlag <= 1'b0;
      else if (misaligned)
         errFlag <= 1'b1;
   end

   assign MisalignErr = errFlag;
`else
   assign misaligned  = 1'b0;
   assign MisalignErr = 1'b0;
`endif

   assign push = MemWrite && isStoreOp(funct3) && !misaligned;

   // Pure loads get the array port; everything else lets the buffer drain.
   // Reset clears SBCount asynchronously, so no drain can happen under reset.
   assign drain = (SBCount != '0) && !(MemRead && !MemWrite);

   assign pushEntry.index = 30'(wordIdx);
   assign pushEntry.data  = laneData(Mem_WrData, funct3, offset);
   assign pushEntry.mask  = laneMask(funct3, offset);

   dmem_store_buf #(
      .SB_DEPTH(SB_DEPTH)
   ) u_storeBuf (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pushEntry  (pushEntry),
      .pop        (drain),
      .lookupIndex(30'(wordIdx)),
      .baseWord   (mem[wordIdx]),
      .mergedWord (mergedWord),
      .headEntry  (headVec),
      .count      (SBCount)
   );

   assign head = sbEntry_t'(headVec);

   // Retire the oldest buffered store into the array under its byte mask
   always_ff @(posedge clk) begin
      if (drain) begin
         for (int b = 0; b < 4; b++) begin
            if (head.mask[b])
               mem[head.index[AW-1:0]][8*b +: 8] <= head.data[8*b +: 8];
         end
      end
   end

   assign ReadData = misaligned ? 32'd0 : extractLoad(mergedWord, funct3, offset);
   assign SBEmpty  = (SBCount == '0);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench with program-order memory model
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int SBD   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [31:0] Mem_WrAddr = '0;
   logic [31:0] Mem_WrData = '0;
   logic [2:0]  funct3 = '0;
   logic [31:0] ReadData;
   logic [$clog2(SBD):0] SBCount;
   logic        SBEmpty;
   logic        MisalignErr;

   int nCompared   = 0;
   int nMismatched = 0;
   bit checkOn     = 1'b0;
   int maxCount    = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .SB_DEPTH(SBD)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .Mem_WrAddr (Mem_WrAddr),
      .Mem_WrData (Mem_WrData),
      .funct3     (funct3),
      .ReadData   (ReadData),
      .SBCount    (SBCount),
      .SBEmpty    (SBEmpty),
      .MisalignErr(MisalignErr)
   );

   always #5 clk = ~clk;

   // Model: committed byte array plus an ordered list of pending stores
   typedef struct {
      int          idx;
      logic [31:0] data;
      logic [3:0]  mask;
   } ent_t;

   ent_t        pendQ[$];
   logic [31:0] committed [DEPTH];
   bit          errModel = 1'b0;

   function automatic int idxOf(input logic [31:0] a);
      return int'((a >> 2) & (DEPTH - 1));
   endfunction

   function automatic bit misalignModel(input bit access, input logic [2:0] f, input logic [1:0] off);
`ifdef DMEM_MISALIGN_TRAP_EN
      if (!access) return 1'b0;
      if ((f == 3'b001 || f == 3'b101) && (off % 2 == 1)) return 1'b1;
      if (f == 3'b010 && off != 0) return 1'b1;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic ent_t makeEntry(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      ent_t e;
      int nBytes;
      int start;
      int lane;
      e.idx  = idxOf(a);
      e.data = '0;
      e.mask = '0;
      nBytes = (f == 3'b000) ? 1 : (f == 3'b001) ? 2 : 4;
      start  = (f == 3'b010) ? 0 : int'(a[1:0]);
      for (int k = 0; k < nBytes; k++) begin
         lane = start + k;
         if (lane < 4) begin
            e.mask[lane]        = 1'b1;
            e.data[8*lane +: 8] = d[8*k +: 8];
         end
      end
      return e;
   endfunction

   function automatic logic [31:0] viewWord(input int idx);
      logic [31:0] w;
      w = committed[idx];
      foreach (pendQ[i])
         if (pendQ[i].idx == idx)
            for (int b = 0; b < 4; b++)
               if (pendQ[i].mask[b]) w[8*b +: 8] = pendQ[i].data[8*b +: 8];
      return w;
   endfunction

   function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [2:0] f, input bit wr);
      logic [31:0] w;
      logic [31:0] byteVal;
      logic [31:0] halfVal;
      int off;
      if (misalignModel(1'b1, f, a[1:0]) && (wr || 1'b1)) return 32'd0;
      w       = viewWord(idxOf(a));
      off     = int'(a[1:0]);
      byteVal = (w >> (8 * off)) & 32'hFF;
      halfVal = (w >> (8 * off)) & 32'hFFFF;
      case (f)
         3'b000:  return (byteVal >= 32'h80) ? (byteVal | 32'hFFFF_FF00) : byteVal;
         3'b100:  return byteVal;
         3'b001:  return (halfVal >= 32'h8000) ? (halfVal | 32'hFFFF_0000) : halfVal;
         3'b101:  return halfVal;
         3'b010:  return w;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s at %0t: got 0x%08h required 0x%08h", name, $time, act, exp);
      end
   endtask

   // Model advances on the same edge as the DUT; reset drops pending stores
   always @(posedge clk or negedge reset) begin
      bit doDrain;
      ent_t h;
      if (!reset) begin
         pendQ.delete();
         errModel = 1'b0;
      end else begin
         doDrain = (pendQ.size() > 0) && !(MemRead && !MemWrite);
         if (doDrain) begin
            h = pendQ.pop_front();
            for (int b = 0; b < 4; b++)
               if (h.mask[b]) committed[h.idx][8*b +: 8] = h.data[8*b +: 8];
         end
         if (misalignModel(MemRead || MemWrite, funct3, Mem_WrAddr[1:0]))
            errModel = 1'b1;
         else if (MemWrite && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010))
            pendQ.push_back(makeEntry(Mem_WrAddr, Mem_WrData, funct3));
      end
   end

   // Compare process: outputs against model every cycle out of reset
   always @(negedge clk) begin
      if (checkOn && reset) begin
         check("SBCount", 32'(SBCount), 32'(pendQ.size()));
         check("SBEmpty", 32'(SBEmpty), 32'(pendQ.size() == 0));
         check("MisalignErr", 32'(MisalignErr), 32'(errModel));
         if (int'(SBCount) > maxCount) maxCount = int'(SBCount);
         if (MemRead)
            check("ReadData", ReadData, modelLoad(Mem_WrAddr, funct3, MemWrite));
      end
   end

   task automatic step(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f);
      @(posedge clk);
      #1;
      MemWrite   = wr;
      MemRead    = rd;
      Mem_WrAddr = a;
      Mem_WrData = d;
      funct3     = f;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_SBCount", 32'(SBCount), 32'd0);
      check("reset_SBEmpty", 32'(SBEmpty), 32'd1);
      check("reset_MisalignErr", 32'(MisalignErr), 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      checkOn = 1'b1;

      // Give every word a known value
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 1'b0, 32'(i * 4), $urandom, 3'b010);
      repeat (2) idle();

      // Load hits a still-buffered store
      step(1'b1, 1'b0, 32'h10, 32'h1122_3344, 3'b010);
      step(1'b0, 1'b1, 32'h10, 32'd0, 3'b010);
      check("fwd_LW_0x10", ReadData, 32'h1122_3344);

      // Byte merge after drain
      step(1'b1, 1'b0, 32'h20, 32'hAABB_CCDD, 3'b010);
      step(1'b1, 1'b0, 32'h22, 32'h0000_007F, 3'b000);
      repeat (3) idle();
      check("drained_SBEmpty", 32'(SBEmpty), 32'd1);
      step(1'b0, 1'b1, 32'h20, 32'd0, 3'b010);
      check("LW_0x20", ReadData, 32'hAA7F_CCDD);
      step(1'b0, 1'b1, 32'h23, 32'd0, 3'b000);
      check("LB_0x23", ReadData, 32'hFFFF_FFAA);
      step(1'b0, 1'b1, 32'h23, 32'd0, 3'b100);
      check("LBU_0x23", ReadData, 32'h0000_00AA);

      // Loads block drain
      step(1'b1, 1'b0, 32'h40, 32'h8000_1234, 3'b010);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 32'h40 + 32'(i % 4), 32'd0, 3'($urandom_range(0, 7)));
         check("blocked_SBCount", 32'(SBCount), 32'd1);
      end
      idle();
      step(1'b0, 1'b1, 32'h42, 32'd0, 3'b001);
      check("after_idle_SBCount", 32'(SBCount), 32'd0);
      check("LH_0x42", ReadData, 32'hFFFF_8000);
      step(1'b0, 1'b1, 32'h42, 32'd0, 3'b101);
      check("LHU_0x42", ReadData, 32'h0000_8000);

      // Blocked fill, then interleaved stores/loads past the buffer depth
      step(1'b1, 1'b0, 32'h80, 32'hCAFE_0000, 3'b010);
      repeat (3) step(1'b0, 1'b1, 32'h80, 32'd0, 3'b010);
      for (int i = 0; i < SBD + 2; i++) begin
         step(1'b1, 1'b0, 32'h84 + 32'(4 * i), 32'hCAFE_0001 + 32'(i), 3'b010);
         step(1'b0, 1'b1, 32'h84 + 32'(4 * i), 32'd0, 3'b010);
      end
      repeat (2) idle();
      for (int i = 0; i < SBD + 2; i++)
         step(1'b0, 1'b1, 32'h84 + 32'(4 * i), 32'd0, 3'b010);
      step(1'b0, 1'b1, 32'h84 + 32'(4 * (SBD + 1)), 32'd0, 3'b010);
      check("wrap_LW_last", ReadData, 32'hCAFE_0001 + 32'(SBD + 1));

      // Reset drops buffered stores
      step(1'b1, 1'b0, 32'h08, 32'h1, 3'b010);
      step(1'b1, 1'b0, 32'h08, 32'h2, 3'b010);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("inreset_SBCount", 32'(SBCount), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("postreset_SBCount", 32'(SBCount), 32'd0);
      check("postreset_MisalignErr", 32'(MisalignErr), 32'd0);
      step(1'b0, 1'b1, 32'h08, 32'd0, 3'b010);
      check("postreset_LW_0x08", ReadData, 32'h1);

      // Random traffic over all sizes, offsets and high address bits
      for (int i = 0; i < 1500; i++) begin
         logic wr;
         logic rd;
         wr = ($urandom_range(0, 2) == 0);
         rd = ($urandom_range(0, 1) == 0);
         step(wr, rd, $urandom, $urandom, 3'($urandom_range(0, 7)));
      end
      repeat (2) idle();
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 1'b1, 32'(i * 4), 32'd0, 3'b010);

      nCompared++;
      if (maxCount > SBD) begin
         nMismatched++;
         $display("FAIL SBCount_bound: got %0d required <= %0d", maxCount, SBD);
      end

      checkOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
